// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcode and subcode encodings,
// the decoded-flag bundle, the fetch-buffer entry and the decode helper.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_SUB  = 4'h0,
        OP_MOVL = 4'h8,
        OP_MOVH = 4'h9,
        OP_JMP  = 4'hE,
        OP_MEM  = 4'hF
    } opcode_t;

    localparam logic [3:0] SUB_JZ  = 4'h0;
    localparam logic [3:0] SUB_JNZ = 4'h1;
    localparam logic [3:0] SUB_JS  = 4'h2;
    localparam logic [3:0] SUB_JNS = 4'h3;
    localparam logic [3:0] SUB_LD  = 4'h0;
    localparam logic [3:0] SUB_ST  = 4'h1;

    typedef struct packed {
        logic is_sub;
        logic is_movl;
        logic is_movh;
        logic is_jmp;
        logic is_mem;
        logic is_jz;
        logic is_jnz;
        logic is_js;
        logic is_jns;
        logic is_ld;
        logic is_st;
    } dec_flags_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } fetch_entry_t;

    // Unknown encodings yield all-zero flags; the instruction still flows on.
    function automatic dec_flags_t decode_ins(input logic [15:0] ins);
        dec_flags_t f;
        logic [3:0] op;
        logic [3:0] sb;
        op = ins[15:12];
        sb = ins[7:4];
        f = '0;
        f.is_sub  = (op == OP_SUB);
        f.is_movl = (op == OP_MOVL);
        f.is_movh = (op == OP_MOVH);
        f.is_jmp  = (op == OP_JMP);
        f.is_mem  = (op == OP_MEM);
        f.is_jz   = f.is_jmp && (sb == SUB_JZ);
        f.is_jnz  = f.is_jmp && (sb == SUB_JNZ);
        f.is_js   = f.is_jmp && (sb == SUB_JS);
        f.is_jns  = f.is_jmp && (sb == SUB_JNS);
        f.is_ld   = f.is_mem && (sb == SUB_LD);
        f.is_st   = f.is_mem && (sb == SUB_ST);
        return f;
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Synchronous instruction buffer of fetch entries with occupancy count and
// a synchronous clear used on pipeline flush.
module ins_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_decode_pipe.sv
// Fetch/decode front end: owns the PC, issues reads on memory port 0 under a
// credit limit, buffers returned words and presents the decoded d_* bundle.
// Optional build macro FETCH_BYPASS_EN lets a returning word skip the empty
// buffer and load the decode stage directly, saving one cycle.
module fetch_decode_pipe
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] flushPc,
    output logic [15:0] memRAddr0,
    input  logic [15:0] memData0,
    output logic        d_valid,
    output logic [15:0] d_pc,
    output logic [15:0] d_ins,
    output logic        d_isSub,
    output logic        d_isMovl,
    output logic        d_isMovh,
    output logic        d_isJmp,
    output logic        d_isMem,
    output logic        d_isJz,
    output logic        d_isJnz,
    output logic        d_isJs,
    output logic        d_isJns,
    output logic        d_isLd,
    output logic        d_isSt,
    output logic [3:0]  regRAddr0,
    output logic [3:0]  regRAddr1
);

    localparam int CW  = $clog2(FIFO_DEPTH + MEM_LAT + 1) + 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]        pc;
    logic [MEM_LAT-1:0] tag_valid;
    logic [15:0]        tag_pc [MEM_LAT];
    logic               exit_valid;
    logic [15:0]        exit_pc;
    logic [CW-1:0]      inflight;
    logic               issue;
    logic               bypass;

    fetch_entry_t       fifo_wdata;
    fetch_entry_t       fifo_head;
    logic [FCW-1:0]     fifo_count;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    logic               load_en;
    fetch_entry_t       load_src;
    dec_flags_t         d_flags;

    assign memRAddr0  = pc;
    assign exit_valid = tag_valid[MEM_LAT-1];
    assign exit_pc    = tag_pc[MEM_LAT-1];

    // Count outstanding reads so buffer plus in-flight never exceeds the buffer size.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + CW'(tag_valid[i]);
        end
    end

    assign issue = !flush && ((CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH));

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && !stall && !flush && exit_valid;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_wdata = '{pc: exit_pc, ins: memData0};
    assign fifo_push  = !flush && exit_valid && !bypass;
    assign fifo_pop   = !flush && !stall && !fifo_empty;

    // PC advances by one word per issue; a flush redirects it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= flushPc;
        end else if (issue) begin
            pc <= pc + 16'd2;
        end
    end

    // Tag pipe mirrors the memory latency so each returning word knows its PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_pc[i] <= '0;
            end
        end else begin
            tag_valid[0] <= issue;
            tag_pc[0]    <= pc;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_valid[i] <= flush ? 1'b0 : tag_valid[i-1];
                tag_pc[i]    <= tag_pc[i-1];
            end
        end
    end

    ins_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Select what the decode stage loads: the bypassed word or the buffer head.
    always_comb begin
        load_en  = 1'b0;
        load_src = fifo_head;
        if (bypass) begin
            load_en  = 1'b1;
            load_src = '{pc: exit_pc, ins: memData0};
        end else if (fifo_pop) begin
            load_en  = 1'b1;
        end
    end

    // Decode stage register: flush kills it, stall freezes it, otherwise it refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_pc    <= '0;
            d_ins   <= '0;
            d_flags <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (!stall) begin
            d_valid <= load_en;
            if (load_en) begin
                d_pc    <= load_src.pc;
                d_ins   <= load_src.ins;
                d_flags <= decode_ins(load_src.ins);
            end
        end
    end

    assign d_isSub  = d_flags.is_sub;
    assign d_isMovl = d_flags.is_movl;
    assign d_isMovh = d_flags.is_movh;
    assign d_isJmp  = d_flags.is_jmp;
    assign d_isMem  = d_flags.is_mem;
    assign d_isJz   = d_flags.is_jz;
    assign d_isJnz  = d_flags.is_jnz;
    assign d_isJs   = d_flags.is_js;
    assign d_isJns  = d_flags.is_jns;
    assign d_isLd   = d_flags.is_ld;
    assign d_isSt   = d_flags.is_st;

    assign regRAddr0 = d_ins[11:8];
    assign regRAddr1 = d_isSub ? d_ins[7:4] : d_ins[3:0];

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Self-checking bench for fetch_decode_pipe: directed scenarios followed by
// randomized stall/flush traffic, checked against a stream-level model.
module tb_fetch_decode_pipe;

    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MEM_LAT    = 2;
`ifdef FETCH_BYPASS_EN
    localparam int          FIRST_LAT  = 3;
`else
    localparam int          FIRST_LAT  = 4;
`endif

    localparam logic [10:0] F_SUB  = 11'b100_0000_0000;
    localparam logic [10:0] F_MOVL = 11'b010_0000_0000;
    localparam logic [10:0] F_MOVH = 11'b001_0000_0000;
    localparam logic [10:0] F_JMP  = 11'b000_1000_0000;
    localparam logic [10:0] F_MEM  = 11'b000_0100_0000;
    localparam logic [10:0] F_JZ   = 11'b000_0010_0000;
    localparam logic [10:0] F_JNZ  = 11'b000_0001_0000;
    localparam logic [10:0] F_JS   = 11'b000_0000_1000;
    localparam logic [10:0] F_JNS  = 11'b000_0000_0100;
    localparam logic [10:0] F_LD   = 11'b000_0000_0010;
    localparam logic [10:0] F_ST   = 11'b000_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] flushPc = 16'h0;
    logic [15:0] memRAddr0;
    logic [15:0] memData0;
    logic        d_valid;
    logic [15:0] d_pc;
    logic [15:0] d_ins;
    logic        d_isSub, d_isMovl, d_isMovh, d_isJmp, d_isMem;
    logic        d_isJz, d_isJnz, d_isJs, d_isJns, d_isLd, d_isSt;
    logic [3:0]  regRAddr0;
    logic [3:0]  regRAddr1;
    logic [10:0] dut_flags;

    logic [15:0] mem [512];
    logic [15:0] addr_pipe [MEM_LAT];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_pc;
    logic        m_valid;
    logic [15:0] m_pc;
    int          starve;

    fetch_decode_pipe #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MEM_LAT    (MEM_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .flushPc   (flushPc),
        .memRAddr0 (memRAddr0),
        .memData0  (memData0),
        .d_valid   (d_valid),
        .d_pc      (d_pc),
        .d_ins     (d_ins),
        .d_isSub   (d_isSub),
        .d_isMovl  (d_isMovl),
        .d_isMovh  (d_isMovh),
        .d_isJmp   (d_isJmp),
        .d_isMem   (d_isMem),
        .d_isJz    (d_isJz),
        .d_isJnz   (d_isJnz),
        .d_isJs    (d_isJs),
        .d_isJns   (d_isJns),
        .d_isLd    (d_isLd),
        .d_isSt    (d_isSt),
        .regRAddr0 (regRAddr0),
        .regRAddr1 (regRAddr1)
    );

    assign dut_flags = {d_isSub, d_isMovl, d_isMovh, d_isJmp, d_isMem,
                        d_isJz, d_isJnz, d_isJs, d_isJns, d_isLd, d_isSt};

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory read port: the word for an address appears MEM_LAT cycles later.
    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            addr_pipe[i] <= addr_pipe[i-1];
        end
        addr_pipe[0] <= memRAddr0;
    end

    always_comb memData0 = mem[addr_pipe[MEM_LAT-1][9:1]];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return mem[a[9:1]];
    endfunction

    function automatic logic [10:0] ref_flags(input logic [15:0] ins);
        logic [3:0] op;
        logic [3:0] sb;
        logic [10:0] r;
        op = ins[15:12];
        sb = ins[7:4];
        case (op)
            4'h0: r = F_SUB;
            4'h8: r = F_MOVL;
            4'h9: r = F_MOVH;
            4'hE: r = F_JMP | ((sb == 4'd0) ? F_JZ : (sb == 4'd1) ? F_JNZ :
                               (sb == 4'd2) ? F_JS : (sb == 4'd3) ? F_JNS : 11'b0);
            4'hF: r = F_MEM | ((sb == 4'd0) ? F_LD : (sb == 4'd1) ? F_ST : 11'b0);
            default: r = 11'b0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Compare the d bundle with the model given the inputs the last edge saw.
    task automatic model_check(input logic s, input logic f, input logic [15:0] fp);
        logic [15:0] w;
        if (f) begin
            checkOutput("flush_dvalid", 32'(d_valid), 32'd0);
            checkOutput("flush_pc", 32'(memRAddr0), 32'(fp));
            exp_pc  = fp;
            m_valid = 1'b0;
            starve  = 0;
        end else if (s) begin
            checkOutput("stall_dvalid", 32'(d_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("stall_dpc", 32'(d_pc), 32'(m_pc));
                checkOutput("stall_dins", 32'(d_ins), 32'(mem_word(m_pc)));
            end
        end else if (d_valid) begin
            w = mem_word(exp_pc);
            checkOutput("seq_pc", 32'(d_pc), 32'(exp_pc));
            checkOutput("seq_ins", 32'(d_ins), 32'(w));
            checkOutput("seq_flags", 32'(dut_flags), 32'(ref_flags(w)));
            checkOutput("seq_ra0", 32'(regRAddr0), 32'(w[11:8]));
            checkOutput("seq_ra1", 32'(regRAddr1), 32'((w[15:12] == 4'h0) ? w[7:4] : w[3:0]));
            m_valid = 1'b1;
            m_pc    = exp_pc;
            exp_pc  = exp_pc + 16'd2;
            starve  = 0;
        end else begin
            m_valid = 1'b0;
            starve++;
            checkOutput("starve", 32'(starve < FIRST_LAT), 32'd1);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic f, input logic [15:0] fp);
        stall   = s;
        flush   = f;
        flushPc = fp;
        @(posedge clk);
        @(negedge clk);
        model_check(s, f, fp);
    endtask

    task automatic model_reset();
        exp_pc  = RESET_PC;
        m_valid = 1'b0;
        m_pc    = RESET_PC;
        starve  = 0;
    endtask

    // Run idle cycles until d_valid rises and check how many edges it took.
    task automatic wait_first(input string tag);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 16'h0);
            n++;
        end while (!d_valid && n < 20);
        checkOutput(tag, 32'(n), 32'(FIRST_LAT));
    endtask

    initial begin
        logic [15:0] exp_addr;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 16'($urandom);
        end
        for (int i = 0; i < MEM_LAT; i++) begin
            addr_pipe[i] = 16'h0;
        end
        mem[0]    = 16'h0231;
        mem[1]    = 16'h8413;
        mem[2]    = 16'hE003;
        mem[9'h80] = 16'h0123;
        mem[9'h81] = 16'h9A53;
        mem[9'h82] = 16'hF012;
        mem[9'h83] = 16'hF052;
        mem[9'h84] = 16'h3000;
        model_reset();

        // Reset values
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_dvalid", 32'(d_valid), 32'd0);
        checkOutput("rst_addr", 32'(memRAddr0), 32'(RESET_PC));
        checkOutput("rst_dpc", 32'(d_pc), 32'd0);
        checkOutput("rst_dins", 32'(d_ins), 32'd0);
        checkOutput("rst_flags", 32'(dut_flags), 32'd0);
        rst_n = 1'b1;

        // First fetches after reset release
        wait_first("first_lat");
        checkOutput("first_sub", 32'(dut_flags), 32'(F_SUB));
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("second_pc", 32'(d_pc), 32'h2);
        checkOutput("second_movl", 32'(dut_flags), 32'(F_MOVL));
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("third_jz", 32'(dut_flags), 32'(F_JMP | F_JZ));

        // Decode patterns at 0x0100
        applyStimulus(1'b0, 1'b1, 16'h0100);
        wait_first("dec_lat");
        checkOutput("dec_ra0", 32'(regRAddr0), 32'h1);
        checkOutput("dec_ra1", 32'(regRAddr1), 32'h2);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("movh_ra1", 32'(regRAddr1), 32'h3);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("st_flags", 32'(dut_flags), 32'(F_MEM | F_ST));
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("memonly_flags", 32'(dut_flags), 32'(F_MEM));
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("bad_flags", 32'(dut_flags), 32'd0);
        checkOutput("bad_valid", 32'(d_valid), 32'd1);

        // Long stall: d frozen, fetch stops once FIFO_DEPTH words are outstanding
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0);
            if (i >= 2) begin
                exp_addr = m_pc + 16'(2 * (FIFO_DEPTH + 1));
                checkOutput("credit_addr", 32'(memRAddr0), 32'(exp_addr));
            end
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0);
            checkOutput("nogap", 32'(d_valid), 32'd1);
        end

        // Flush with words in flight
        applyStimulus(1'b0, 1'b1, 16'h0040);
        wait_first("flush_lat");
        checkOutput("flush_target", 32'(d_pc), 32'h0040);

        // PC wrap at 16 bits
        applyStimulus(1'b0, 1'b1, 16'hFFFC);
        wait_first("wrap_lat");
        applyStimulus(1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("wrap_pc", 32'(d_pc), 32'h0);

        // Flush together with stall
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'h0080);
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("fs_seq", 32'(exp_pc > 16'h0080), 32'd1);

        // Reset in the middle of a stall with a full buffer
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_dvalid", 32'(d_valid), 32'd0);
        checkOutput("midrst_addr", 32'(memRAddr0), 32'(RESET_PC));
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        model_reset();
        wait_first("midrst_lat");
        checkOutput("midrst_pc", 32'(d_pc), 32'(RESET_PC));

        // Randomized stall/flush traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 20),
                          1'($urandom_range(0, 99) < 3),
                          16'($urandom_range(0, 511)) << 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
